// File: rtl/ov7670_capture.sv
// OV7670 capture: samples the camera parallel bus in the clk domain and pairs bytes into RGB565 pixels with linear addresses.
// Latency: pixel_valid rises 3 clk edges after the first edge that samples cam_pclk high for a pixel's second byte.
// Backpressure: none; the camera cannot be stalled, so every accepted pixel is strobed out immediately.
//
// Optional feature macro: OV7670_CAPTURE_FRAME_COUNT_EN (frame_count counter; tied to 0 when undefined).
//
// Ports:
//   clk, rst_n          system clock (>= 3x cam_pclk), async active-low reset
//   enable              level-sensitive capture enable (configuration done)
//   cam_pclk/vsync/href camera timing inputs, asynchronous to clk
//   cam_data[7:0]       camera data bus
//   pixel_data[15:0]    RGB565 pixel, first byte in [15:8]; holds between strobes
//   pixel_valid         one-cycle strobe qualifying pixel_data/pixel_addr
//   pixel_addr          linear address of the most recent pixel, 0 at frame start
//   frame_done          one-cycle pulse at the end of a captured frame
//   frame_error         sticky: wrong pixel count or odd-byte line
//   frame_count[15:0]   completed-frame counter
module ov7670_capture #(
  parameter int H_PIXELS = 640,
  parameter int V_LINES  = 480,
  parameter int ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              cam_pclk,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  output logic [15:0]       pixel_data,
  output logic              pixel_valid,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic              frame_done,
  output logic              frame_error,
  output logic [15:0]       frame_count
);

  // One extra bit so the counter can reach the full frame size.
  localparam int                CNT_W   = ADDR_W + 1;
  localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(H_PIXELS * V_LINES);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_FRAME = 2'd1,
    S_CAPTURE    = 2'd2,
    S_FRAME_END  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Synchronisers (s1, s2) plus history flop for edge detection.
  logic       r_pclk_s1, r_pclk_s2, r_pclk_h;
  logic       r_vs_s1, r_vs_s2, r_vs_h;
  logic       r_href_s1, r_href_s2, r_href_h;
  logic [7:0] r_data_s1, r_data_s2;

  // Registered edge events with data/HREF aligned to the PCLK rise.
  logic       r_pclk_rise, r_vs_rise, r_vs_fall, r_href_fall, r_href_d;
  logic [7:0] r_data_d;

  logic              r_en_d;
  logic              r_phase;
  logic [7:0]        r_hi;
  logic [CNT_W-1:0]  r_pix_cnt;
  logic              r_ovf;
  logic [15:0]       r_pixel_data;
  logic              r_pixel_valid;
  logic [ADDR_W-1:0] r_pixel_addr;
  logic              r_frame_done;
  logic              r_frame_error;

  logic w_pclk_rise, w_vs_rise, w_vs_fall, w_href_fall;
  logic w_en_rise;
  logic w_frame_start, w_byte_hi, w_pix_emit, w_pix_ovf, w_half_drop, w_done;
  logic w_frame_bad;

  assign w_pclk_rise = r_pclk_s2 & ~r_pclk_h;
  assign w_vs_rise   = r_vs_s2   & ~r_vs_h;
  assign w_vs_fall   = ~r_vs_s2  &  r_vs_h;
  assign w_href_fall = ~r_href_s2 & r_href_h;
  assign w_en_rise   = enable & ~r_en_d;
  assign w_frame_bad = (r_pix_cnt != TOTAL_C) || r_ovf;

  // Input synchronisation and edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pclk_s1   <= 1'b0;
      r_pclk_s2   <= 1'b0;
      r_pclk_h    <= 1'b0;
      r_vs_s1     <= 1'b0;
      r_vs_s2     <= 1'b0;
      r_vs_h      <= 1'b0;
      r_href_s1   <= 1'b0;
      r_href_s2   <= 1'b0;
      r_href_h    <= 1'b0;
      r_data_s1   <= 8'h00;
      r_data_s2   <= 8'h00;
      r_pclk_rise <= 1'b0;
      r_vs_rise   <= 1'b0;
      r_vs_fall   <= 1'b0;
      r_href_fall <= 1'b0;
      r_href_d    <= 1'b0;
      r_data_d    <= 8'h00;
    end else begin
      r_pclk_s1   <= cam_pclk;
      r_pclk_s2   <= r_pclk_s1;
      r_pclk_h    <= r_pclk_s2;
      r_vs_s1     <= cam_vsync;
      r_vs_s2     <= r_vs_s1;
      r_vs_h      <= r_vs_s2;
      r_href_s1   <= cam_href;
      r_href_s2   <= r_href_s1;
      r_href_h    <= r_href_s2;
      r_data_s1   <= cam_data;
      r_data_s2   <= r_data_s1;
      r_pclk_rise <= w_pclk_rise;
      r_vs_rise   <= w_vs_rise;
      r_vs_fall   <= w_vs_fall;
      r_href_fall <= w_href_fall;
      r_href_d    <= r_href_s2;
      r_data_d    <= r_data_s2;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and per-cycle control strobes.
  always_comb begin
    w_state_nxt   = r_state;
    w_frame_start = 1'b0;
    w_byte_hi     = 1'b0;
    w_pix_emit    = 1'b0;
    w_pix_ovf     = 1'b0;
    w_half_drop   = 1'b0;
    w_done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable) w_state_nxt = S_WAIT_FRAME;
      end
      S_WAIT_FRAME: begin
        if (r_vs_fall) begin
          w_frame_start = 1'b1;
          w_state_nxt   = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (r_pclk_rise && r_href_d) begin
          if (!r_phase)                w_byte_hi  = 1'b1;
          else if (r_pix_cnt == TOTAL_C) w_pix_ovf = 1'b1;
          else                         w_pix_emit = 1'b1;
        end else if (r_href_fall && r_phase) begin
          w_half_drop = 1'b1;
        end
        // A pixel completing in the same cycle is still taken above;
        // the extra FRAME_END cycle puts frame_done after its strobe.
        if (r_vs_rise) w_state_nxt = S_FRAME_END;
      end
      S_FRAME_END: begin
        w_done      = 1'b1;
        w_state_nxt = S_WAIT_FRAME;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Disable aborts everything, including any strobe due this cycle.
    if (!enable) begin
      w_state_nxt   = S_IDLE;
      w_frame_start = 1'b0;
      w_byte_hi     = 1'b0;
      w_pix_emit    = 1'b0;
      w_pix_ovf     = 1'b0;
      w_half_drop   = 1'b0;
      w_done        = 1'b0;
    end
  end

  // Byte pairing, addressing and status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en_d        <= 1'b0;
      r_phase       <= 1'b0;
      r_hi          <= 8'h00;
      r_pix_cnt     <= '0;
      r_ovf         <= 1'b0;
      r_pixel_data  <= 16'h0000;
      r_pixel_valid <= 1'b0;
      r_pixel_addr  <= '0;
      r_frame_done  <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_en_d        <= enable;
      r_pixel_valid <= w_pix_emit;
      r_frame_done  <= w_done;
      if (w_frame_start) begin
        r_phase      <= 1'b0;
        r_pix_cnt    <= '0;
        r_ovf        <= 1'b0;
        r_pixel_addr <= '0;
      end else begin
        if (w_byte_hi) begin
          r_hi    <= r_data_d;
          r_phase <= 1'b1;
        end
        if (w_pix_emit) begin
          r_pixel_data <= {r_hi, r_data_d};
          r_pixel_addr <= r_pix_cnt[ADDR_W-1:0];
          r_pix_cnt    <= r_pix_cnt + CNT_W'(1);
          r_phase      <= 1'b0;
        end
        // Excess pixels are swallowed; the address holds at the last slot.
        if (w_pix_ovf) begin
          r_ovf   <= 1'b1;
          r_phase <= 1'b0;
        end
        if (w_half_drop) r_phase <= 1'b0;
      end
      if (w_en_rise) begin
        r_frame_error <= 1'b0;
      end else if (w_half_drop || (w_done && w_frame_bad)) begin
        r_frame_error <= 1'b1;
      end
    end
  end

`ifdef OV7670_CAPTURE_FRAME_COUNT_EN
  logic [15:0] r_frame_count;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_count <= 16'h0000;
    end else if (w_done) begin
      r_frame_count <= r_frame_count + 16'd1;
    end
  end
  assign frame_count = r_frame_count;
`else
  assign frame_count = 16'h0000;
`endif

  assign pixel_data  = r_pixel_data;
  assign pixel_valid = r_pixel_valid;
  assign pixel_addr  = r_pixel_addr;
  assign frame_done  = r_frame_done;
  assign frame_error = r_frame_error;

endmodule

// File: tb/tb_ov7670_capture.sv
// Directed bench for ov7670_capture with a 4x2 frame and clk = 4x pclk.
module tb_ov7670_capture;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int AW = 3;
`ifdef OV7670_CAPTURE_FRAME_COUNT_EN
  localparam logic [15:0] EXP_FC3 = 16'd3;
`else
  localparam logic [15:0] EXP_FC3 = 16'd0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          cam_pclk = 1'b0;
  logic          cam_vsync = 1'b1;
  logic          cam_href = 1'b0;
  logic [7:0]    cam_data = 8'h00;
  logic [15:0]   pixel_data;
  logic          pixel_valid;
  logic [AW-1:0] pixel_addr;
  logic          frame_done;
  logic          frame_error;
  logic [15:0]   frame_count;

  int vectors = 0;
  int miscompares = 0;

  // Monitor state (written only by the monitor, cleared by tests).
  int            mon_pv = 0;
  int            mon_done = 0;
  int            mon_max_addr = 0;
  logic [15:0]   mon_data [0:31];
  logic [AW-1:0] mon_addr [0:31];

  ov7670_capture #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
    .pixel_data(pixel_data), .pixel_valid(pixel_valid), .pixel_addr(pixel_addr),
    .frame_done(frame_done), .frame_error(frame_error), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pixel_valid) begin
      if (mon_pv < 32) begin
        mon_data[mon_pv] = pixel_data;
        mon_addr[mon_pv] = pixel_addr;
      end
      if (int'(pixel_addr) > mon_max_addr) mon_max_addr = int'(pixel_addr);
      mon_pv = mon_pv + 1;
    end
    if (frame_done) mon_done = mon_done + 1;
  end

  // ---------------- camera stimulus ----------------
  task automatic send_byte(input logic [7:0] b, input logic href);
    cam_data = b;
    cam_href = href;
    repeat (2) @(negedge clk);
    cam_pclk = 1'b1;
    repeat (2) @(negedge clk);
    cam_pclk = 1'b0;
  endtask

  task automatic idle_pclk(input int n);
    for (int i = 0; i < n; i++) send_byte(8'h00, 1'b0);
  endtask

  task automatic send_line(input logic [7:0] first, input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = first + 8'(i);
      send_byte(b, 1'b1);
    end
    idle_pclk(2);
  endtask

  task automatic frame_start();
    cam_vsync = 1'b1;
    idle_pclk(2);
    cam_vsync = 1'b0;
    idle_pclk(2);
  endtask

  task automatic frame_end();
    idle_pclk(1);
    cam_vsync = 1'b1;
    idle_pclk(3);
  endtask

  task automatic clear_mon();
    mon_pv = 0;
    mon_done = 0;
    mon_max_addr = 0;
  endtask

  task automatic reenable();
    @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    enable = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic good_frame();
    frame_start();
    send_line(8'h00, 8);
    send_line(8'h08, 8);
    frame_end();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    cam_data = 8'hFF;
    repeat (3) @(negedge clk);
    vectors++; if ({pixel_data, pixel_valid, pixel_addr} !== {16'h0, 1'b0, 3'h0}) begin
      miscompares++; $display("FAIL reset_pixel: got data=%h vld=%b addr=%0d want 0", pixel_data, pixel_valid, pixel_addr); end
    vectors++; if ({frame_done, frame_error, frame_count} !== {1'b0, 1'b0, 16'h0}) begin
      miscompares++; $display("FAIL reset_status: got done=%b err=%b cnt=%0d want 0", frame_done, frame_error, frame_count); end
    rst_n = 1'b1;
    cam_data = 8'h00;
    repeat (4) @(negedge clk);
    vectors++; if (pixel_valid !== 1'b0) begin
      miscompares++; $display("FAIL post_reset_idle: pixel_valid=%b want 0", pixel_valid); end
  endtask

  task automatic test_basic_frame();
    logic [15:0] exp_d;
    enable = 1'b1;
    repeat (2) @(negedge clk);
    clear_mon();
    good_frame();
    vectors++; if (mon_pv !== 8) begin
      miscompares++; $display("FAIL basic_count: got %0d strobes want 8", mon_pv); end
    for (int i = 0; i < 8; i++) begin
      exp_d = {8'(2*i), 8'(2*i+1)};
      vectors++; if (mon_data[i] !== exp_d || mon_addr[i] !== AW'(i)) begin
        miscompares++; $display("FAIL basic_pix%0d: got %h@%0d want %h@%0d", i, mon_data[i], mon_addr[i], exp_d, i); end
    end
    vectors++; if (mon_done !== 1 || frame_error !== 1'b0) begin
      miscompares++; $display("FAIL basic_done: got done=%0d err=%b want 1/0", mon_done, frame_error); end
    vectors++; if (pixel_data !== 16'h0E0F || pixel_addr !== 3'd7) begin
      miscompares++; $display("FAIL basic_hold: got %h@%0d want 0e0f@7", pixel_data, pixel_addr); end
  endtask

  task automatic test_latency();
    clear_mon();
    frame_start();
    send_byte(8'hA5, 1'b1);
    cam_data = 8'h5A;
    cam_href = 1'b1;
    repeat (2) @(negedge clk);
    cam_pclk = 1'b1;
    @(posedge clk);            // edge that first samples pclk high
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (pixel_valid !== 1'b0) begin
      miscompares++; $display("FAIL latency_early: pixel_valid=%b after 2 edges want 0", pixel_valid); end
    @(posedge clk);
    #1;
    vectors++; if (pixel_valid !== 1'b1 || pixel_data !== 16'hA55A || pixel_addr !== 3'd0) begin
      miscompares++; $display("FAIL latency_edge3: got vld=%b %h@%0d want 1 a55a@0", pixel_valid, pixel_data, pixel_addr); end
    @(posedge clk);
    #1;
    vectors++; if (pixel_valid !== 1'b0) begin
      miscompares++; $display("FAIL latency_pulse: pixel_valid=%b want 0", pixel_valid); end
    @(negedge clk);
    cam_pclk = 1'b0;
    cam_href = 1'b0;
    idle_pclk(2);
    frame_end();
    vectors++; if (mon_done !== 1 || frame_error !== 1'b1) begin
      miscompares++; $display("FAIL latency_short_end: got done=%0d err=%b want 1/1", mon_done, frame_error); end
  endtask

  task automatic test_odd_bytes();
    reenable();
    vectors++; if (frame_error !== 1'b0) begin
      miscompares++; $display("FAIL odd_cleared: frame_error=%b want 0", frame_error); end
    clear_mon();
    frame_start();
    send_line(8'h10, 3);
    vectors++; if (mon_pv !== 1 || mon_data[0] !== 16'h1011 || frame_error !== 1'b1) begin
      miscompares++; $display("FAIL odd_line: got n=%0d %h err=%b want 1 1011 1", mon_pv, mon_data[0], frame_error); end
    send_line(8'h20, 4);
    vectors++; if (mon_pv !== 3 || mon_data[1] !== 16'h2021 || mon_addr[1] !== 3'd1
                   || mon_data[2] !== 16'h2223 || mon_addr[2] !== 3'd2) begin
      miscompares++; $display("FAIL odd_next_line: got n=%0d %h@%0d %h@%0d want 3 2021@1 2223@2",
                              mon_pv, mon_data[1], mon_addr[1], mon_data[2], mon_addr[2]); end
    frame_end();
    vectors++; if (mon_done !== 1) begin
      miscompares++; $display("FAIL odd_done: got %0d want 1", mon_done); end
  endtask

  task automatic test_short_frame();
    reenable();
    clear_mon();
    frame_start();
    send_line(8'h00, 8);
    send_line(8'h40, 4);
    frame_end();
    vectors++; if (mon_pv !== 6 || mon_done !== 1 || frame_error !== 1'b1) begin
      miscompares++; $display("FAIL short_frame: got n=%0d done=%0d err=%b want 6 1 1", mon_pv, mon_done, frame_error); end
  endtask

  task automatic test_long_frame();
    reenable();
    clear_mon();
    frame_start();
    send_line(8'h00, 12);
    send_line(8'h20, 8);
    vectors++; if (mon_pv !== 8 || frame_error !== 1'b0) begin
      miscompares++; $display("FAIL long_before_end: got n=%0d err=%b want 8 0", mon_pv, frame_error); end
    vectors++; if (pixel_addr !== 3'd7 || pixel_data !== 16'h2223) begin
      miscompares++; $display("FAIL long_hold: got %h@%0d want 2223@7", pixel_data, pixel_addr); end
    frame_end();
    vectors++; if (mon_done !== 1 || frame_error !== 1'b1 || mon_max_addr !== 7 || mon_pv !== 8) begin
      miscompares++; $display("FAIL long_end: got done=%0d err=%b max=%0d n=%0d want 1 1 7 8",
                              mon_done, frame_error, mon_max_addr, mon_pv); end
  endtask

  task automatic test_midframe_disable();
    clear_mon();
    frame_start();
    send_line(8'h50, 6);
    @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (mon_pv !== 3 || frame_error !== 1'b1) begin
      miscompares++; $display("FAIL mid_disabled: got n=%0d err=%b want 3 1", mon_pv, frame_error); end
    enable = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if (frame_error !== 1'b0) begin
      miscompares++; $display("FAIL mid_reenable_clear: frame_error=%b want 0", frame_error); end
    send_line(8'h60, 4);
    frame_end();
    vectors++; if (mon_pv !== 3 || mon_done !== 0) begin
      miscompares++; $display("FAIL mid_skipped: got n=%0d done=%0d want 3 0", mon_pv, mon_done); end
    clear_mon();
    frame_start();
    send_line(8'h70, 8);
    send_line(8'h78, 8);
    frame_end();
    vectors++; if (mon_pv !== 8 || mon_addr[0] !== 3'd0 || mon_data[0] !== 16'h7071
                   || mon_done !== 1 || frame_error !== 1'b0) begin
      miscompares++; $display("FAIL mid_restart: got n=%0d %h@%0d done=%0d err=%b want 8 7071@0 1 0",
                              mon_pv, mon_data[0], mon_addr[0], mon_done, frame_error); end
  endtask

  task automatic test_frame_count();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (frame_count !== 16'h0) begin
      miscompares++; $display("FAIL fc_reset: got %0d want 0", frame_count); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    clear_mon();
    for (int f = 0; f < 3; f++) good_frame();
    vectors++; if (mon_done !== 3 || frame_error !== 1'b0 || frame_count !== EXP_FC3) begin
      miscompares++; $display("FAIL frame_count: got done=%0d err=%b cnt=%0d want 3 0 %0d",
                              mon_done, frame_error, frame_count, EXP_FC3); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_latency();
    test_odd_bytes();
    test_short_frame();
    test_long_frame();
    test_midframe_disable();
    test_frame_count();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ov7670_capture.md
Name: ov7670_capture

Overview:
- Downstream neighbour of the camera configuration block; starts capturing once configuration reports done.
- Samples the OV7670 parallel bus (PCLK, VSYNC, HREF, D[7:0]) in the system clock domain and pairs bytes into RGB565 pixels.
- Emits one pixel strobe per pixel, with a linear frame-buffer write address.
- Reports frame completion and frame-size errors to the frame-buffer writer.

Parameters:
- H_PIXELS, 640, pixels per line.
- V_LINES, 480, lines per frame.
- ADDR_W, 19, width of pixel_addr; must satisfy 2^ADDR_W >= H_PIXELS*V_LINES.

Ports:
- clk  in  1  system clock; must be >= 3x cam_pclk frequency.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  driven from configuration done; level-sensitive capture enable.
- cam_pclk  in  1  camera pixel clock, asynchronous to clk.
- cam_vsync  in  1  camera VSYNC; high during vertical blanking.
- cam_href  in  1  camera HREF; high while line bytes are valid.
- cam_data  in  8  camera data bus.
- pixel_data  out  16  RGB565 pixel, first byte in [15:8].
- pixel_valid  out  1  one-cycle strobe qualifying pixel_data and pixel_addr.
- pixel_addr  out  ADDR_W  linear address of the current pixel, 0 at frame start.
- frame_done  out  1  one-cycle pulse at end of a captured frame.
- frame_error  out  1  sticky flag: a frame had the wrong pixel count or an odd-byte line.
- frame_count  out  16  completed-frame counter (optional feature).

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state IDLE, synchronisers 0, byte phase 0.
- Synchronisation:
  - cam_pclk, cam_vsync, cam_href and cam_data pass through a 2-flop synchroniser plus one history flop.
  - PCLK rise = sync2 high while history low. VSYNC rise/fall are detected the same way.
  - Data and HREF are taken from the sync2 stage, aligned with the PCLK rise.
- Latency: pixel_valid rises exactly 3 clk edges after the first clk edge that samples cam_pclk high for the second byte of a pixel.
- FSM:
  - IDLE: wait for enable=1, then go to WAIT_FRAME.
  - WAIT_FRAME: wait for a VSYNC falling edge. Then clear pixel_addr counter, pixel count and byte phase, and go to CAPTURE. Frames already in progress when enable rises are skipped.
  - CAPTURE: on each PCLK rise with HREF=1:
    - Phase 0: latch byte into the high half; phase becomes 1.
    - Phase 1: form pixel, assert pixel_valid for one cycle with the current address; address +1; phase becomes 0.
  - CAPTURE, HREF falling with phase=1: drop the half pixel, set frame_error, reset phase to 0.
  - CAPTURE, VSYNC rising edge: pulse frame_done for one cycle. Set frame_error if pixel count != H_PIXELS*V_LINES. Return to WAIT_FRAME.
- Overflow: after H_PIXELS*V_LINES pixels, further pixels in the same frame produce no pixel_valid. pixel_addr holds at the last valid address (H_PIXELS*V_LINES-1), and frame_error is set at frame end.
- enable deasserted in any state: return to IDLE on the next clk; no frame_done; pixel_valid forced 0 that cycle. The partial frame is discarded.
- frame_error clears only on reset, or on the enable 0->1 transition.
- pixel_data holds its value between strobes. pixel_addr shows the address of the most recent pixel, or 0 after frame start.
- Simultaneous VSYNC rise and final PCLK rise: the pixel is emitted first (pixel_valid), then frame_done on the next cycle.

Optional Feature:
- Macro: OV7670_CAPTURE_FRAME_COUNT_EN.
- Defined: frame_count increments by 1 (wraps at 16 bits) on every frame_done; it resets to 0 on reset.
- Undefined: frame_count is tied to 0 and no counter logic is synthesised. Port list is unchanged.

Test Plan:
- Reset then enable=1, H_PIXELS=4, V_LINES=2, clk = 4x pclk, 16 bytes 0x00..0x0F in one frame -> 8 pixel_valid strobes with data 0x0001,0x0203,...,0x0E0F and addr 0..7; frame_done once; frame_error=0.
- Latency check: single pixel, then measure from the clk edge sampling the second pclk high -> pixel_valid exactly 3 clk edges later.
- Odd byte count: 3 bytes on one line -> 1 pixel strobe; frame_error=1 after HREF falls; second line is captured from phase 0.
- Short frame: 6 pixels then VSYNC rise (expecting 8) -> frame_done pulse and frame_error=1. Long frame of 10 pixels -> exactly 8 strobes, addr never exceeds 7, frame_error=1.
- Mid-frame enable=0 after 3 pixels, then re-enable -> no frame_done. Capture restarts at the next VSYNC fall with addr 0, and frame_error is cleared on re-enable.
- With OV7670_CAPTURE_FRAME_COUNT_EN: 3 good frames -> frame_count=3. Without the macro -> frame_count stays 0.
